// File: rtl/sdram_req_queue_module.sv
// -----------------------------------------------------------------------------
// sdram_req_queue_module
//   Request queue in front of an SDRAM controller stage. User requests
//   {write, address, data} are buffered in a small FIFO and issued one at a
//   time to the SDRAM stage with a registered write or read enable, held until
//   the stage pulses Done_Sig. Read data is returned with a one-cycle strobe.
//
// Parameters
//   DEPTH_LOG2   FIFO holds 2**DEPTH_LOG2 entries
//   TIMEOUT_CYC  watchdog limit in ISSUE clocks (only with SDRAM_REQ_TIMEOUT_EN)
//
// Build option
//   SDRAM_REQ_TIMEOUT_EN  when defined, an operation that sees no Done_Sig for
//                         TIMEOUT_CYC clocks is abandoned and Timeout_Sig is set
//                         (sticky). When undefined, ISSUE waits indefinitely
//                         and Timeout_Sig is tied to 0.
//
// Ports
//   CLK, RSTn            clock, asynchronous active-low reset
//   Req_Valid/Write/Addr/Data   user request (accepted when Req_Ready=1)
//   Req_Ready            FIFO not full
//   WrEN_Sig, RdEN_Sig   enables to the SDRAM stage (never both high)
//   BRC_Addr, WrData     address / write data to the SDRAM stage
//   Done_Sig             completion pulse from the SDRAM stage
//   Busy_Sig             SDRAM stage busy (init/refresh); blocks new issue
//   RdData               read data from the SDRAM stage
//   Rd_Valid, Rd_Data    one-cycle read-return strobe and data
//   Timeout_Sig          sticky watchdog flag
// -----------------------------------------------------------------------------
module sdram_req_queue_module #(
    parameter int unsigned DEPTH_LOG2  = 2,
    parameter int unsigned TIMEOUT_CYC = 1023
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        Req_Valid,
    input  logic        Req_Write,
    input  logic [21:0] Req_Addr,
    input  logic [15:0] Req_Data,
    output logic        Req_Ready,
    output logic        WrEN_Sig,
    output logic        RdEN_Sig,
    input  logic        Done_Sig,
    input  logic        Busy_Sig,
    output logic [21:0] BRC_Addr,
    output logic [15:0] WrData,
    input  logic [15:0] RdData,
    output logic        Rd_Valid,
    output logic [15:0] Rd_Data,
    output logic        Timeout_Sig
);

    localparam int unsigned          LP_DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]  LP_FULL  = (DEPTH_LOG2 + 1)'(LP_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_GAP   = 2'd2
    } t_state;

    t_state                 r_state;
    logic [38:0]            r_mem [0:LP_DEPTH-1];
    logic [DEPTH_LOG2-1:0]  r_wptr;
    logic [DEPTH_LOG2-1:0]  r_rptr;
    logic [DEPTH_LOG2:0]    r_count;
    logic                   r_wren;
    logic                   r_rden;
    logic [21:0]            r_addr;
    logic [15:0]            r_wdata;
    logic                   r_rd_valid;
    logic [15:0]            r_rd_data;

    logic                   w_push;
    logic                   w_pop;
    logic                   w_wd_expire;
    logic [38:0]            w_head;

    // Ready comes from the registered count only, so a pop in the same
    // cycle does not open a slot until the next cycle.
    assign Req_Ready = (r_count < LP_FULL);
    assign w_push    = Req_Valid & Req_Ready;
    // The head leaves the FIFO when its operation retires: completed by the
    // SDRAM stage or abandoned by the watchdog.
    assign w_pop     = (r_state == S_ISSUE) & (Done_Sig | w_wd_expire);
    assign w_head    = r_mem[r_rptr];

    // ---------------------------------------------------------------------
    // FIFO storage and pointers
    // ---------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wptr] <= {Req_Write, Req_Addr, Req_Data};
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + DEPTH_LOG2'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + DEPTH_LOG2'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (DEPTH_LOG2 + 1)'(1);
                2'b01:   r_count <= r_count - (DEPTH_LOG2 + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Optional watchdog
    // ---------------------------------------------------------------------
`ifdef SDRAM_REQ_TIMEOUT_EN
    localparam int unsigned LP_WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [LP_WD_W-1:0] r_wdog;
    logic               r_timeout;

    // r_wdog holds the number of ISSUE clocks already elapsed; the check fires
    // on the TIMEOUT_CYC-th one. Done_Sig wins if both happen together.
    assign w_wd_expire = (r_state == S_ISSUE) && !Done_Sig &&
                         (r_wdog == LP_WD_W'(TIMEOUT_CYC - 1));
    assign Timeout_Sig = r_timeout;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_wdog    <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (r_state != S_ISSUE) begin
                r_wdog <= '0;
            end else if (!Done_Sig) begin
                r_wdog <= r_wdog + LP_WD_W'(1);
            end
            if (w_wd_expire) begin
                r_timeout <= 1'b1;
            end
        end
    end
`else
    logic w_unused_timeout;

    assign w_wd_expire      = 1'b0;
    assign Timeout_Sig      = 1'b0;
    assign w_unused_timeout = ^TIMEOUT_CYC;
`endif

    // ---------------------------------------------------------------------
    // Issue state machine with registered outputs
    // ---------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state    <= S_IDLE;
            r_wren     <= 1'b0;
            r_rden     <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if ((r_count != '0) && !Busy_Sig) begin
                        r_state <= S_ISSUE;
                        r_wren  <= w_head[38];
                        r_rden  <= ~w_head[38];
                        r_addr  <= w_head[37:16];
                        r_wdata <= w_head[15:0];
                    end
                end
                S_ISSUE: begin
                    if (Done_Sig) begin
                        r_state <= S_GAP;
                        r_wren  <= 1'b0;
                        r_rden  <= 1'b0;
                        if (r_rden) begin
                            r_rd_valid <= 1'b1;
                            r_rd_data  <= RdData;
                        end
                    end else if (w_wd_expire) begin
                        r_state <= S_GAP;
                        r_wren  <= 1'b0;
                        r_rden  <= 1'b0;
                    end
                end
                S_GAP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_wren  <= 1'b0;
                    r_rden  <= 1'b0;
                end
            endcase
        end
    end

    assign WrEN_Sig = r_wren;
    assign RdEN_Sig = r_rden;
    assign BRC_Addr = r_addr;
    assign WrData   = r_wdata;
    assign Rd_Valid = r_rd_valid;
    assign Rd_Data  = r_rd_data;

endmodule

// File: tb/tb_sdram_req_queue_module.sv
// -----------------------------------------------------------------------------
// Testbench for sdram_req_queue_module. Accepted requests are pushed to a
// scoreboard queue when driven; each issued operation is compared against the
// scoreboard head and popped when it retires. Inputs change and outputs are
// sampled 1 ns after the rising clock edge.
// Define SDRAM_REQ_TIMEOUT_EN for both files to exercise the watchdog.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sdram_req_queue_module;

    localparam int unsigned DEPTH = 4;

    typedef struct packed {
        logic        wr;
        logic [21:0] addr;
        logic [15:0] data;
    } t_req;

    logic        CLK = 1'b0;
    logic        RSTn = 1'b0;
    logic        Req_Valid = 1'b0;
    logic        Req_Write = 1'b0;
    logic [21:0] Req_Addr = '0;
    logic [15:0] Req_Data = '0;
    logic        Req_Ready;
    logic        WrEN_Sig;
    logic        RdEN_Sig;
    logic        Done_Sig = 1'b0;
    logic        Busy_Sig = 1'b0;
    logic [21:0] BRC_Addr;
    logic [15:0] WrData;
    logic [15:0] RdData = '0;
    logic        Rd_Valid;
    logic [15:0] Rd_Data;
    logic        Timeout_Sig;

    int   n_checks = 0;
    int   n_fail   = 0;
    t_req sb[$];
    t_req nop = '0;

    sdram_req_queue_module #(
        .DEPTH_LOG2  (2),
        .TIMEOUT_CYC (15)
    ) dut (
        .CLK         (CLK),
        .RSTn        (RSTn),
        .Req_Valid   (Req_Valid),
        .Req_Write   (Req_Write),
        .Req_Addr    (Req_Addr),
        .Req_Data    (Req_Data),
        .Req_Ready   (Req_Ready),
        .WrEN_Sig    (WrEN_Sig),
        .RdEN_Sig    (RdEN_Sig),
        .Done_Sig    (Done_Sig),
        .Busy_Sig    (Busy_Sig),
        .BRC_Addr    (BRC_Addr),
        .WrData      (WrData),
        .RdData      (RdData),
        .Rd_Valid    (Rd_Valid),
        .Rd_Data     (Rd_Data),
        .Timeout_Sig (Timeout_Sig)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL global_time_limit: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1);
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Present one request for one edge; the scoreboard accepts it only if the
    // model FIFO (pending + in-flight entries) has room.
    task automatic push_req(input logic w, input logic [21:0] a, input logic [15:0] d);
        t_req r;
        r.wr = w; r.addr = a; r.data = d;
        Req_Valid = 1'b1;
        Req_Write = w;
        Req_Addr  = a;
        Req_Data  = d;
        if (sb.size() < DEPTH) sb.push_back(r);
        tick();
        Req_Valid = 1'b0;
    endtask

    // Wait for the next issue, compare it with the scoreboard head, hold it for
    // 'hold' extra cycles, complete it with Done_Sig and check the retire/gap.
    task automatic serve_next(input int hold, input logic [15:0] rdata,
                              input bit also_push, input t_req ap, output int waited);
        t_req exp;
        waited = 0;
        while (!(WrEN_Sig || RdEN_Sig) && waited < 60) begin
            tick();
            waited++;
        end
        n_checks++;
        if (!(WrEN_Sig || RdEN_Sig)) begin
            n_fail++;
            $display("FAIL issue_wait: no enable after %0d cycles, required an enable", waited);
            return;
        end
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_issue: WrEN=%b RdEN=%b addr=%h, required no issue", WrEN_Sig, RdEN_Sig, BRC_Addr);
            return;
        end
        exp = sb[0];
        if (WrEN_Sig !== exp.wr || RdEN_Sig !== !exp.wr || BRC_Addr !== exp.addr || WrData !== exp.data) begin
            n_fail++;
            $display("FAIL issue_content: WrEN=%b RdEN=%b addr=%h data=%h, required WrEN=%b RdEN=%b addr=%h data=%h",
                     WrEN_Sig, RdEN_Sig, BRC_Addr, WrData, exp.wr, !exp.wr, exp.addr, exp.data);
        end
        for (int i = 0; i < hold; i++) begin
            tick();
            n_checks++;
            if (WrEN_Sig !== exp.wr || RdEN_Sig !== !exp.wr || BRC_Addr !== exp.addr || WrData !== exp.data) begin
                n_fail++;
                $display("FAIL issue_hold: cycle %0d WrEN=%b RdEN=%b addr=%h data=%h, required held WrEN=%b addr=%h data=%h",
                         i, WrEN_Sig, RdEN_Sig, BRC_Addr, WrData, exp.wr, exp.addr, exp.data);
            end
        end
        Done_Sig = 1'b1;
        RdData   = rdata;
        if (also_push) begin
            Req_Valid = 1'b1;
            Req_Write = ap.wr;
            Req_Addr  = ap.addr;
            Req_Data  = ap.data;
            if (sb.size() < DEPTH) sb.push_back(ap);
        end
        tick();
        Done_Sig  = 1'b0;
        Req_Valid = 1'b0;
        RdData    = '0;
        void'(sb.pop_front());
        n_checks++;
        if (WrEN_Sig !== 1'b0 || RdEN_Sig !== 1'b0 || Rd_Valid !== !exp.wr) begin
            n_fail++;
            $display("FAIL retire: WrEN=%b RdEN=%b Rd_Valid=%b, required 0 0 %b", WrEN_Sig, RdEN_Sig, Rd_Valid, !exp.wr);
        end
        if (!exp.wr) begin
            n_checks++;
            if (Rd_Data !== rdata) begin
                n_fail++;
                $display("FAIL read_data: Rd_Data=%h, required %h", Rd_Data, rdata);
            end
        end
        tick();
        n_checks++;
        if (WrEN_Sig !== 1'b0 || RdEN_Sig !== 1'b0 || Rd_Valid !== 1'b0) begin
            n_fail++;
            $display("FAIL gap: WrEN=%b RdEN=%b Rd_Valid=%b, required 0 0 0", WrEN_Sig, RdEN_Sig, Rd_Valid);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge CLK);
        #1;
        n_checks++;
        if (WrEN_Sig !== 1'b0 || RdEN_Sig !== 1'b0 || Rd_Valid !== 1'b0 || Timeout_Sig !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: WrEN=%b RdEN=%b Rd_Valid=%b Timeout=%b, required all 0",
                     WrEN_Sig, RdEN_Sig, Rd_Valid, Timeout_Sig);
        end
        n_checks++;
        if (BRC_Addr !== 22'h0 || WrData !== 16'h0 || Rd_Data !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_data: addr=%h wdata=%h rdata=%h, required all 0", BRC_Addr, WrData, Rd_Data);
        end
        n_checks++;
        if (Req_Ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: Req_Ready=%b, required 1", Req_Ready);
        end
        RSTn = 1'b1;
        tick();
    endtask

    task automatic test_single_write();
        int w;
        push_req(1'b1, 22'h000123, 16'hA5A5);
        n_checks++;
        if (WrEN_Sig !== 1'b0 || RdEN_Sig !== 1'b0) begin
            n_fail++;
            $display("FAIL latency_early: WrEN=%b RdEN=%b one clock after request, required 0 0", WrEN_Sig, RdEN_Sig);
        end
        tick();
        n_checks++;
        if (WrEN_Sig !== 1'b1 || BRC_Addr !== 22'h000123 || WrData !== 16'hA5A5) begin
            n_fail++;
            $display("FAIL latency_2clk: WrEN=%b addr=%h data=%h, required 1 000123 a5a5", WrEN_Sig, BRC_Addr, WrData);
        end
        serve_next(3, 16'h0000, 1'b0, nop, w);
    endtask

    task automatic test_read_return();
        int w;
        push_req(1'b0, 22'h3FFFFF, 16'h0000);
        serve_next(1, 16'h5A5A, 1'b0, nop, w);
    endtask

    task automatic test_full_fifo();
        int w;
        logic any_en;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (Req_Ready !== (i < 4)) begin
                n_fail++;
                $display("FAIL full_ready_before_push%0d: Req_Ready=%b, required %b", i, Req_Ready, (i < 4));
            end
            push_req((i % 2) == 0, 22'(32'h100 + i), 16'(32'h1000 + i));
        end
        n_checks++;
        if (Req_Ready !== 1'b0) begin
            n_fail++;
            $display("FAIL full_ready: Req_Ready=%b after 5 pushes, required 0", Req_Ready);
        end
        for (int i = 0; i < 4; i++) begin
            serve_next(0, 16'(32'hC000 + i), 1'b0, nop, w);
        end
        any_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            any_en = any_en | WrEN_Sig | RdEN_Sig;
        end
        n_checks++;
        if (any_en !== 1'b0) begin
            n_fail++;
            $display("FAIL full_fifth_dropped: enable seen after 4 ops, required none");
        end
        n_checks++;
        if (Req_Ready !== 1'b1) begin
            n_fail++;
            $display("FAIL full_drained_ready: Req_Ready=%b, required 1", Req_Ready);
        end
    endtask

    task automatic test_busy();
        int w;
        logic any_en;
        Busy_Sig = 1'b1;
        push_req(1'b1, 22'h0ABCDE, 16'h1234);
        push_req(1'b0, 22'h155555, 16'h4321);
        any_en = 1'b0;
        for (int i = 0; i < 18; i++) begin
            any_en = any_en | WrEN_Sig | RdEN_Sig;
            tick();
        end
        any_en = any_en | WrEN_Sig | RdEN_Sig;
        n_checks++;
        if (any_en !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_block: enable asserted while Busy_Sig=1, required none");
        end
        Busy_Sig = 1'b0;
        tick();
        n_checks++;
        if (WrEN_Sig !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_release: WrEN=%b one clock after Busy_Sig fell, required 1", WrEN_Sig);
        end
        // Busy rising during ISSUE must not stall completion.
        Busy_Sig = 1'b1;
        serve_next(2, 16'h0000, 1'b0, nop, w);
        any_en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            any_en = any_en | WrEN_Sig | RdEN_Sig;
        end
        n_checks++;
        if (any_en !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_second_blocked: enable asserted while Busy_Sig=1, required none");
        end
        Busy_Sig = 1'b0;
        serve_next(0, 16'hBEEF, 1'b0, nop, w);
        n_checks++;
        if (w != 1) begin
            n_fail++;
            $display("FAIL busy_second_latency: issued %0d clocks after release, required 1", w);
        end
    endtask

    task automatic test_back_to_back();
        int   w;
        t_req ap;
        for (int i = 0; i < 3; i++) begin
            push_req(1'($urandom_range(0, 1)), 22'($urandom), 16'($urandom));
        end
        ap.wr = 1'b0; ap.addr = 22'h2AAAAA; ap.data = 16'h7777;
        // Push coincides with the pop of the head: count must stay at 3.
        serve_next(0, 16'($urandom), 1'b1, ap, w);
        n_checks++;
        if (Req_Ready !== 1'b1) begin
            n_fail++;
            $display("FAIL push_pop_ready: Req_Ready=%b with 3 entries, required 1", Req_Ready);
        end
        push_req(1'b1, 22'h011111, 16'h2222);
        n_checks++;
        if (Req_Ready !== 1'b0) begin
            n_fail++;
            $display("FAIL push_pop_full: Req_Ready=%b with 4 entries, required 0", Req_Ready);
        end
        for (int i = 0; i < 4; i++) begin
            serve_next(0, 16'($urandom), 1'b0, nop, w);
            if (i > 0) begin
                n_checks++;
                if (w != 1) begin
                    n_fail++;
                    $display("FAIL issue_spacing%0d: waited %0d clocks after gap, required 1", i, w);
                end
            end
        end
    endtask

`ifdef SDRAM_REQ_TIMEOUT_EN
    task automatic test_timeout();
        int w;
        int hi;
        push_req(1'b0, 22'h0F0F0F, 16'h0000);
        push_req(1'b1, 22'h300001, 16'h9999);
        n_checks++;
        if (Timeout_Sig !== 1'b0 || RdEN_Sig !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_start: Timeout=%b RdEN=%b, required 0 1", Timeout_Sig, RdEN_Sig);
        end
        hi = 0;
        while (RdEN_Sig === 1'b1 && hi < 100) begin
            hi++;
            tick();
        end
        n_checks++;
        if (hi != 15) begin
            n_fail++;
            $display("FAIL timeout_length: enable held %0d clocks, required 15", hi);
        end
        n_checks++;
        if (Timeout_Sig !== 1'b1 || Rd_Valid !== 1'b0 || WrEN_Sig !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_flag: Timeout=%b Rd_Valid=%b WrEN=%b, required 1 0 0", Timeout_Sig, Rd_Valid, WrEN_Sig);
        end
        void'(sb.pop_front());
        serve_next(0, 16'h0000, 1'b0, nop, w);
        n_checks++;
        if (Timeout_Sig !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_sticky: Timeout=%b, required 1", Timeout_Sig);
        end
    endtask
`else
    task automatic test_no_timeout();
        int   w;
        logic bad;
        push_req(1'b1, 22'h0F0F0F, 16'h6666);
        tick();
        bad = 1'b0;
        for (int i = 0; i < 40; i++) begin
            bad = bad | (WrEN_Sig !== 1'b1) | (Timeout_Sig !== 1'b0);
            tick();
        end
        n_checks++;
        if (bad !== 1'b0) begin
            n_fail++;
            $display("FAIL no_timeout_wait: WrEN=%b Timeout=%b during long wait, required 1 0", WrEN_Sig, Timeout_Sig);
        end
        serve_next(0, 16'h0000, 1'b0, nop, w);
    endtask
`endif

    task automatic test_reset_midop();
        int   w;
        logic bad;
        push_req(1'b0, 22'h222222, 16'h0000);
        push_req(1'b1, 22'h333333, 16'h3333);
        push_req(1'b1, 22'h044444, 16'h4444);
        n_checks++;
        if (RdEN_Sig !== 1'b1) begin
            n_fail++;
            $display("FAIL midop_issue: RdEN=%b, required 1", RdEN_Sig);
        end
        #2;
        RSTn = 1'b0;
        #1;
        n_checks++;
        if (WrEN_Sig !== 1'b0 || RdEN_Sig !== 1'b0 || Req_Ready !== 1'b1 || Rd_Valid !== 1'b0 ||
            Timeout_Sig !== 1'b0 || BRC_Addr !== 22'h0) begin
            n_fail++;
            $display("FAIL midop_async_reset: WrEN=%b RdEN=%b Ready=%b Rd_Valid=%b Timeout=%b addr=%h, required 0 0 1 0 0 0",
                     WrEN_Sig, RdEN_Sig, Req_Ready, Rd_Valid, Timeout_Sig, BRC_Addr);
        end
        Done_Sig = 1'b1;
        RdData   = 16'hDEAD;
        tick();
        tick();
        RSTn = 1'b1;
        sb.delete();
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            bad = bad | Rd_Valid | WrEN_Sig | RdEN_Sig | !Req_Ready;
        end
        Done_Sig = 1'b0;
        RdData   = '0;
        n_checks++;
        if (bad !== 1'b0) begin
            n_fail++;
            $display("FAIL midop_after_reset: Rd_Valid/enable seen or not ready after reset, required idle and ready");
        end
        push_req(1'b1, 22'h0BEEF0, 16'hCAFE);
        serve_next(1, 16'h0000, 1'b0, nop, w);
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_read_return();
        test_full_fifo();
        test_busy();
        test_back_to_back();
`ifdef SDRAM_REQ_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
